mem_responder: RTL and testbench

- Memory-side responder for the processor load/store request interface.
- Accepts one request at a time (processor_req with load or store, addr, datatomem), models parameterised wait states, and performs the word access on an internal single-port array.
- Returns completion through processor_resp/mem_done, with read data on datafrommem and datatoinst.
- Sits between the processor/IU and the memory subsystem, in place of the MSS, for block-level and integration testing.

---
 rtl/mem_responder_pkg.sv | 39 +++
 rtl/mem_responder_mem_array.sv | 29 ++
 rtl/mem_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: bus widths, FSM state and
// request-decode enumerations, and the request classification helper.
package mem_responder_pkg;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ACCESS = 3'd2,
        RESP   = 3'd3,
        DRAIN  = 3'd4
    } mem_state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_STORE = 2'd2,
        CMD_BAD   = 2'd3
    } mem_cmd_t;

    // Classify a request. Exactly one of load/store must be set and the
    // address must be in range; anything else is rejected later with error=1.
    function automatic mem_cmd_t decode_cmd(input logic load,
                                            input logic store,
                                            input logic addr_ok);
        mem_cmd_t cmd;
        if (load == store) begin
            cmd = (load == 1'b0) ? CMD_NONE : CMD_BAD;
        end else if (!addr_ok) begin
            cmd = CMD_BAD;
        end else begin
            cmd = load ? CMD_LOAD : CMD_STORE;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM with write enable and registered read.
// Contents are deliberately not reset so they survive a responder reset.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      idx,
    input  logic [MEM_DATA_W-1:0] wdata,
    output logic [MEM_DATA_W-1:0] rdata
);

    logic [MEM_DATA_W-1:0] mem_r [DEPTH];

    // Storage write and registered read share the single address port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one load/store request at a time, inserts
// WAIT_STATES wait cycles, performs the word access and returns a one-cycle
// completion pulse. The request is 4-phase: a held request is served once.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  processor_req,
    input  logic                  load,
    input  logic                  store,
    input  logic [MEM_ADDR_W-1:0] addr,
    input  logic [MEM_DATA_W-1:0] datatomem,
    output logic [MEM_DATA_W-1:0] datafrommem,
    output logic [7:0]            datatoinst,
    output logic                  processor_resp,
    output logic                  mem_done,
    output logic                  error
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [MEM_ADDR_W:0] DEPTH_L = (MEM_ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [3:0] WS_L = 4'(WAIT_STATES);

    mem_state_t            state_r;
    mem_state_t            next_state_s;
    logic [3:0]            cnt_r;
    mem_cmd_t              cmd_r;
    mem_cmd_t              req_cmd_s;
    logic [IDX_W-1:0]      addr_r;
    logic [MEM_DATA_W-1:0] wdata_r;
    logic                  addr_ok_s;

    logic                  mem_we_s;
    logic                  mem_re_s;
    logic [IDX_W-1:0]      mem_idx_s;
    logic [MEM_DATA_W-1:0] mem_rdata_s;

    logic [MEM_DATA_W-1:0] dfm_r;
    logic [7:0]            dti_r;
    logic                  resp_r;
    logic                  err_r;

    assign addr_ok_s = ({1'b0, addr} < DEPTH_L);
    assign req_cmd_s = decode_cmd(load, store, addr_ok_s);

    // Next-state decode for the request/wait/access/response sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (processor_req) begin
                    next_state_s = (WS_L == 4'd0) ? ACCESS : WAIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                // <= 1 rather than == 1 so a corrupted zero count cannot hang.
                if (cnt_r <= 4'd1) begin
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = WAIT;
                end
            end
            ACCESS: next_state_s = RESP;
            RESP:   next_state_s = DRAIN;
            DRAIN: begin
                if (!processor_req) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // RAM control: the read is launched on the edge entering ACCESS so its
    // data is ready to register into datafrommem at the ACCESS edge; the write
    // happens at the ACCESS edge. In IDLE the live address feeds the RAM
    // because the zero-wait path enters ACCESS on the latch edge itself.
    always_comb begin
        mem_re_s  = (next_state_s == ACCESS);
        mem_we_s  = (state_r == ACCESS) && (cmd_r == CMD_STORE);
        mem_idx_s = addr_r;
        if (state_r == IDLE) begin
            mem_idx_s = addr[IDX_W-1:0];
        end else begin
            mem_idx_s = addr_r;
        end
    end

    mem_array #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .idx   (mem_idx_s),
        .wdata (wdata_r),
        .rdata (mem_rdata_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture in IDLE; later input changes are ignored until DRAIN exits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_r   <= CMD_NONE;
            addr_r  <= {IDX_W{1'b0}};
            wdata_r <= {MEM_DATA_W{1'b0}};
        end else if ((state_r == IDLE) && processor_req) begin
            cmd_r   <= req_cmd_s;
            addr_r  <= addr[IDX_W-1:0];
            wdata_r <= datatomem;
        end
    end

    // Wait-state counter: loaded on the latch edge, counts down in WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= 4'd0;
        end else if ((state_r == IDLE) && processor_req) begin
            cnt_r <= WS_L;
        end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Response and read-data registers, updated at the ACCESS edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_r <= 1'b0;
            err_r  <= 1'b0;
            dfm_r  <= {MEM_DATA_W{1'b0}};
            dti_r  <= 8'h00;
        end else begin
            resp_r <= (state_r == ACCESS);
            err_r  <= (state_r == ACCESS) &&
                      (cmd_r != CMD_LOAD) && (cmd_r != CMD_STORE);
            if ((state_r == ACCESS) && (cmd_r == CMD_LOAD)) begin
                dfm_r <= mem_rdata_s;
                dti_r <= mem_rdata_s[7:0];
            end
        end
    end

    assign datafrommem    = dfm_r;
    assign datatoinst     = dti_r;
    assign processor_resp = resp_r;
    assign mem_done       = resp_r;
    assign error          = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with two wait states and
// one with zero wait states, checked against a word-array reference model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req [2];
    logic        ldv [2];
    logic        stv [2];
    logic [13:0] adr [2];
    logic [15:0] din [2];
    logic [15:0] dfm [2];
    logic [7:0]  dti [2];
    logic        rsp [2];
    logic        done [2];
    logic        err [2];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ws [2] = '{2, 0};
    int resp_cyc [2];

    logic [15:0] mdl [2][1024];
    bit          kn  [2][1024];
    logic [15:0] exp_dfm [2];
    bit          exp_known [2];

    mem_responder #(.MEM_DEPTH(1024), .WAIT_STATES(2)) dut_ws2 (
        .clk(clk), .reset_n(reset_n), .processor_req(req[0]), .load(ldv[0]),
        .store(stv[0]), .addr(adr[0]), .datatomem(din[0]), .datafrommem(dfm[0]),
        .datatoinst(dti[0]), .processor_resp(rsp[0]), .mem_done(done[0]), .error(err[0])
    );

    mem_responder #(.MEM_DEPTH(1024), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .reset_n(reset_n), .processor_req(req[1]), .load(ldv[1]),
        .store(stv[1]), .addr(adr[1]), .datatomem(din[1]), .datafrommem(dfm[1]),
        .datatoinst(dti[1]), .processor_resp(rsp[1]), .mem_done(done[1]), .error(err[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One request/response handshake on instance s, checked against the model.
    task automatic txn(input int s, input logic l, input logic st,
                       input logic [13:0] a, input logic [15:0] d, input int hold);
        int n;
        int pulses;
        logic valid;
        valid = (l ^ st) && (a < 14'd1024);
        if (valid && st) begin
            mdl[s][a[9:0]] = d;
            kn[s][a[9:0]]  = 1'b1;
        end
        if (valid && l) begin
            exp_known[s] = kn[s][a[9:0]];
            exp_dfm[s]   = mdl[s][a[9:0]];
        end
        @(negedge clk);
        req[s] = 1'b1; ldv[s] = l; stv[s] = st; adr[s] = a; din[s] = d;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1; n++;
            if (rsp[s] === 1'b1) break;
            if (n == 1) begin
                ldv[s] = 1'($urandom); stv[s] = 1'($urandom);
                adr[s] = 14'($urandom); din[s] = 16'($urandom);
            end
        end
        resp_cyc[s] = cyc;
        total++;
        if (rsp[s] !== 1'b1 || n != ws[s] + 2) begin
            bad++;
            $display("FAIL latency inst=%0d addr=%h: resp=%b after %0d edges, required resp=1 after %0d",
                     s, a, rsp[s], n, ws[s] + 2);
        end
        total++;
        if (err[s] !== !valid || done[s] !== 1'b1) begin
            bad++;
            $display("FAIL resp_flags inst=%0d addr=%h ld=%b st=%b: error=%b mem_done=%b, required error=%b mem_done=1",
                     s, a, l, st, err[s], done[s], !valid);
        end
        if (exp_known[s]) begin
            total++;
            if (dfm[s] !== exp_dfm[s] || dti[s] !== exp_dfm[s][7:0]) begin
                bad++;
                $display("FAIL read_data inst=%0d addr=%h: datafrommem=%h datatoinst=%h, required %h %h",
                         s, a, dfm[s], dti[s], exp_dfm[s], exp_dfm[s][7:0]);
            end
        end
        pulses = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp[s] !== 1'b0 || done[s] !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL extra_pulse inst=%0d: %0d extra resp cycles while held, required 0", s, pulses);
        end
        @(negedge clk);
        req[s] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; ldv[s] = 1'b0; stv[s] = 1'b0; adr[s] = 14'd0; din[s] = 16'd0;
            exp_dfm[s] = 16'h0000; exp_known[s] = 1'b1;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            total++;
            if (dfm[s] !== 16'h0000 || dti[s] !== 8'h00 || rsp[s] !== 1'b0 ||
                done[s] !== 1'b0 || err[s] !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d: dfm=%h dti=%h resp=%b done=%b err=%b, required all zero",
                         s, dfm[s], dti[s], rsp[s], done[s], err[s]);
            end
        end
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (rsp[0] !== 1'b0 || rsp[1] !== 1'b0) begin
                bad++;
                $display("FAIL spurious_resp: resp=%b%b after reset release, required 00", rsp[0], rsp[1]);
            end
        end
    endtask

    task automatic test_store_load;
        txn(0, 1'b0, 1'b1, 14'h0005, 16'h0A5A, 1);
        txn(0, 1'b0, 1'b1, 14'h0010, 16'hBEEF, 1);
        txn(0, 1'b1, 1'b0, 14'h0010, 16'h0000, 1);
        total++;
        if (dfm[0] !== 16'hBEEF || dti[0] !== 8'hEF) begin
            bad++;
            $display("FAIL beef_readback: dfm=%h dti=%h, required BEEF EF", dfm[0], dti[0]);
        end
    endtask

    task automatic test_invalid;
        txn(0, 1'b1, 1'b1, 14'h0005, 16'hDEAD, 1);
        txn(0, 1'b1, 1'b0, 14'h0400, 16'h0000, 1);
        total++;
        if (dfm[0] !== 16'hBEEF) begin
            bad++;
            $display("FAIL invalid_keeps_data: dfm=%h, required BEEF", dfm[0]);
        end
        txn(0, 1'b1, 1'b0, 14'h0005, 16'h0000, 1);
    endtask

    task automatic test_held;
        txn(0, 1'b0, 1'b1, 14'h0020, 16'h1357, 10);
        txn(0, 1'b1, 1'b0, 14'h0020, 16'h0000, 1);
    endtask

    task automatic test_async_reset;
        int n;
        @(negedge clk);
        req[0] = 1'b1; ldv[0] = 1'b1; stv[0] = 1'b0; adr[0] = 14'h0010;
        n = 0;
        while (n < 20 && rsp[0] !== 1'b1) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (rsp[0] !== 1'b1 || dfm[0] !== 16'hBEEF) begin
            bad++;
            $display("FAIL pre_reset_load: resp=%b dfm=%h, required 1 BEEF", rsp[0], dfm[0]);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (rsp[0] !== 1'b0 || done[0] !== 1'b0 || err[0] !== 1'b0 ||
            dfm[0] !== 16'h0000 || dti[0] !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: resp=%b done=%b err=%b dfm=%h dti=%h, required all zero",
                     rsp[0], done[0], err[0], dfm[0], dti[0]);
        end
        req[0] = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        exp_dfm[0] = 16'h0000; exp_dfm[1] = 16'h0000;
        exp_known[0] = 1'b1; exp_known[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++;
            if (rsp[0] !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_resp: resp=%b, required 0", rsp[0]);
            end
        end
    endtask

    task automatic test_reset_midop;
        txn(0, 1'b0, 1'b1, 14'h0003, 16'h5555, 1);
        @(negedge clk);
        req[0] = 1'b1; ldv[0] = 1'b0; stv[0] = 1'b1; adr[0] = 14'h0003; din[0] = 16'h1234;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_dfm[0] = 16'h0000; exp_dfm[1] = 16'h0000;
        exp_known[0] = 1'b1; exp_known[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            total++;
            if (rsp[0] !== 1'b0) begin
                bad++;
                $display("FAIL abandoned_resp: resp=%b after mid-op reset, required 0", rsp[0]);
            end
        end
        txn(0, 1'b1, 1'b0, 14'h0003, 16'h0000, 1);
    endtask

    task automatic test_ws0_back_to_back;
        int c1;
        logic [15:0] d;
        for (int i = 0; i < 16; i++) begin
            d = 16'($urandom);
            txn(1, 1'b0, 1'b1, 14'(i), d, 1);
            c1 = resp_cyc[1];
            txn(1, 1'b1, 1'b0, 14'(i), 16'h0000, 1);
            total++;
            if (resp_cyc[1] - c1 != ws[1] + 4) begin
                bad++;
                $display("FAIL spacing addr=%0d: %0d cycles between responses, required %0d",
                         i, resp_cyc[1] - c1, ws[1] + 4);
            end
        end
    endtask

    task automatic test_random;
        int s;
        int op;
        int r;
        logic [13:0] a;
        for (int i = 0; i < 40; i++) begin
            s  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 9));
            if (r < 7)       a = 14'($urandom_range(0, 31));
            else if (r == 7) a = 14'd1023;
            else if (r == 8) a = 14'd1024;
            else             a = 14'($urandom);
            txn(s, op[0], op[1], a, 16'($urandom), int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_invalid();
        test_held();
        test_async_reset();
        test_reset_midop();
        test_ws0_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
